// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage feeding the control decoder. Holds the PC, issues a
// single outstanding request to instruction memory, registers the returned
// word together with its PC and presents it to decode with valid/ready.
// Branch/jump redirects from execute reload the PC and squash any in-flight or
// held instruction.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | request outstanding at pc, waiting for imem_ready
// HOLD   | instruction registered, waiting for decode to accept it
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req/addr   fetch request (level) and address to instruction memory
//   imem_rdata      instruction word, valid when imem_ready=1
//   imem_ready      memory response strobe
//   inst_out/pc_out registered instruction and its PC to decode
//   inst_valid      inst_out/pc_out valid
//   inst_ready      decode accepts inst_out
//   redirect_valid  taken branch/jump pulse, redirect_pc is the target
//   misalign_err    one-cycle pulse when the redirect target is not word aligned
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;

   // State register and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_FETCH;
         pc           <= RESET_PC;
         inst_out     <= NOP;
         pc_out       <= 32'h0000_0000;
         inst_valid   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         // Redirect outranks both a memory response and a decode accept:
         // the response is dropped and the held instruction is squashed.
         if (redirect_valid) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            inst_valid <= 1'b0;
         end else begin
            case (state)
               ST_FETCH: begin
                  if (imem_ready) begin
                     inst_out   <= imem_rdata;
                     pc_out     <= pc;
                     inst_valid <= 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (inst_valid && inst_ready) begin
                     pc         <= pc + PC_STEP;
                     inst_valid <= 1'b0;
                  end
               end
               default: begin
                  inst_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: if (imem_ready)                state_nxt = ST_HOLD;
            ST_HOLD:  if (inst_valid && inst_ready)  state_nxt = ST_FETCH;
            default:                                 state_nxt = ST_FETCH;
         endcase
      end
   end

   // Memory-side outputs are pure decodes of registered state, so nothing
   // from decode or execute reaches imem_req/imem_addr combinationally.
   always_comb begin
      imem_req  = (state == ST_FETCH);
      imem_addr = pc;
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        inst_valid;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   inst_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .inst_out       (inst_out),
      .pc_out         (pc_out),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One fetch at addr with `delay` wait cycles, then decode accepts.
   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                            input int delay, input string tag);
      inst_ready = 1'b0;
      for (int i = 0; i < delay; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== addr) begin
            errors++;
            $display("FAIL %s_wait req=%b addr=%h exp req=1 addr=%h", tag, imem_req, imem_addr, addr);
         end
         tick();
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_req req=%b addr=%h valid=%b exp 1 %h 0", tag, imem_req, imem_addr, inst_valid, addr);
      end
      imem_ready = 1'b1;
      imem_rdata = data;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      checks++;
      if (inst_valid !== 1'b1 || inst_out !== data || pc_out !== addr || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_resp valid=%b inst=%h pc=%h req=%b exp 1 %h %h 0", tag, inst_valid, inst_out, pc_out, imem_req, data, addr);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr + 32'd4 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_next req=%b addr=%h valid=%b exp 1 %h 0", tag, imem_req, imem_addr, inst_valid, addr + 32'd4);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
          inst_out !== 32'h0000_0013 || pc_out !== 32'h0 || misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL reset req=%b addr=%h valid=%b inst=%h pc=%h mis=%b exp 1 0 0 00000013 0 0",
                  imem_req, imem_addr, inst_valid, inst_out, pc_out, misalign_err);
      end
   endtask

   task automatic test_seq_fetch();
      fetch_one(32'h0, 32'h0050_0093, 2, "seq0");
      fetch_one(32'h4, 32'h00A0_0113, 2, "seq4");
   endtask

   // pc starts at 8; imem_ready held high, inst_ready held high.
   task automatic test_zero_wait();
      logic [31:0] p;
      imem_ready = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p = 32'h8 + 32'(i) * 32'd4;
         imem_rdata = 32'h1000_0000 + p;
         checks++;
         if (inst_valid !== 1'b0 || imem_addr !== p || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL zw_fetch%0d valid=%b addr=%h exp 0 %h", i, inst_valid, imem_addr, p);
         end
         tick();
         imem_rdata = 32'hFFFF_FFFF;
         checks++;
         if (inst_valid !== 1'b1 || pc_out !== p || inst_out !== 32'h1000_0000 + p) begin
            errors++;
            $display("FAIL zw_hold%0d valid=%b pc=%h inst=%h exp 1 %h %h", i, inst_valid, pc_out, inst_out, p, 32'h1000_0000 + p);
         end
         tick();
      end
      imem_ready = 1'b0;
      inst_ready = 1'b0;
   endtask

   // pc at 0x18; held instruction must survive back-pressure and spurious responses.
   task automatic test_backpressure();
      imem_ready = 1'b1;
      imem_rdata = 32'h0011_8193;
      tick();
      imem_rdata = 32'hBADB_AD00;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_out !== 32'h0011_8193 || pc_out !== 32'h18 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d valid=%b inst=%h pc=%h req=%b exp 1 00118193 18 0", i, inst_valid, inst_out, pc_out, imem_req);
         end
         tick();
      end
      imem_ready = 1'b0;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h1C || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_next req=%b addr=%h valid=%b exp 1 1c 0", imem_req, imem_addr, inst_valid);
      end
   endtask

   task automatic test_redirect();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      redirect_valid = 1'b0; imem_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40 ||
          misalign_err !== 1'b0 || inst_out !== 32'h0011_8193) begin
         errors++;
         $display("FAIL redir_fetch valid=%b req=%b addr=%h mis=%b inst=%h exp 0 1 40 0 00118193",
                  inst_valid, imem_req, imem_addr, misalign_err, inst_out);
      end
      imem_ready = 1'b1; imem_rdata = 32'h0020_0213;
      tick();
      imem_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h40) begin
         errors++;
         $display("FAIL redir_hold_in valid=%b pc=%h exp 1 40", inst_valid, pc_out);
      end
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      inst_ready = 1'b0; redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++;
         $display("FAIL redir_hold valid=%b req=%b addr=%h exp 0 1 40", inst_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_misalign_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'h46;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (imem_addr !== 32'h44 || misalign_err !== 1'b1) begin
         errors++;
         $display("FAIL mis_set addr=%h mis=%b exp 44 1", imem_addr, misalign_err);
      end
      tick();
      checks++;
      if (imem_addr !== 32'h44 || misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL mis_clear addr=%h mis=%b exp 44 0", imem_addr, misalign_err);
      end
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      fetch_one(32'hFFFF_FFFC, 32'h0030_0293, 1, "wrap");
      checks++;
      if (imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_addr addr=%h mis=%b exp 0 0", imem_addr, misalign_err);
      end
   endtask

   task automatic test_reset_mid_fetch();
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      tick();
      redirect_valid = 1'b0;
      rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      tick();
      rst = 1'b0; imem_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 ||
          inst_out !== 32'h0000_0013 || pc_out !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid valid=%b req=%b addr=%h inst=%h pc=%h exp 0 1 0 00000013 0",
                  inst_valid, imem_req, imem_addr, inst_out, pc_out);
      end
      fetch_one(32'h0, 32'h0010_0073, 0, "restart");
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_zero_wait();
      test_backpressure();
      test_redirect();
      test_misalign_wrap();
      test_reset_mid_fetch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
